dsram_responder: RTL and testbench

//  Responder end of the data-SRAM request interface driven from the MEM stage
//  (wen/addr/wdata latched by the EX->MEM pipeline register). Accepts one word

---
 rtl/dsram_pkg.sv | 30 +++
 rtl/dsram_responder_if.sv | 23 ++
 rtl/dsram_bytelane_ram.sv | 36 +++
 rtl/dsram_responder.sv | 127 ++++++++++++
 tb/tb_dsram_responder.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsram_pkg.sv
// Shared types and constants for the data-SRAM responder.
package dsram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Flat state codes for the legacy-style state register
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_RESP = RESP;

    localparam logic [3:0] WEN_NONE = 4'b0000;
    localparam logic [3:0] WEN_WORD = 4'b1111;

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LANES  = 4;

    // Request fields held from accept until the response cycle
    typedef struct packed {
        logic [LANES-1:0]  wen;
        logic [DATA_W-1:0] wdata;
        logic              err;
    } dsram_req_t;

endpackage

// File: rtl/dsram_responder_if.sv
// Request/response bus between the MEM stage and the data-SRAM responder.
interface dsram_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dsram_bytelane_ram.sv
// Word RAM with per-byte write enables and a registered read that returns 0 when idle.
module dsram_bytelane_ram #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    input  logic          rd_en,
    output logic [31:0]   rdata
);

    logic [3:0][7:0] mem [DEPTH_WORDS];

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][i] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= 32'h0;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end else begin
            rdata <= 32'h0;
        end
    end

endmodule

// File: rtl/dsram_responder.sv
// Data-SRAM responder: accepts one word request, waits WAIT_CYCLES, then
// commits the write or returns read data with a one-cycle response pulse.
module dsram_responder
    import dsram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic               clk,
    input logic               rst_n,
    dsram_responder_if.slave  bus
);

    localparam int unsigned       AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0]       WIN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);
    localparam logic [1:0]        ST_FIRST  = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
    localparam logic [WAIT_W-1:0] CNT_FIRST = (WAIT_CYCLES == 0) ? WAIT_W'(0) : WAIT_W'(1);

    logic [1:0]        state_q, state_nxt;
    logic [WAIT_W-1:0] cnt_q, cnt_nxt;
    logic              ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    dsram_req_t        req_q;
    logic [AW-1:0]     idx_q;

    logic              accept;
    logic [31:0]       offset;
    logic              in_range;
    logic [AW-1:0]     idx_in;
    logic [3:0]        ram_we;
    logic              ram_rd;
    logic [31:0]       ram_q;

    // Unsigned subtraction makes addresses below the base wrap out of range
    assign accept   = bus.req_valid && ready_q;
    assign offset   = bus.req_addr - ADDR_BASE;
    assign in_range = offset < WIN_BYTES;
    assign idx_in   = AW'(offset >> 2);

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        ram_we    = WEN_NONE;
        ram_rd    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_FIRST;
                    cnt_nxt   = CNT_FIRST;
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_nxt = ST_RESP;
                    cnt_nxt   = WAIT_W'(0);
                end else begin
                    cnt_nxt   = cnt_q + WAIT_W'(1);
                end
            end
            ST_RESP: begin
                if (!req_q.err && rst_n) begin
                    ram_we = req_q.wen;
                end
                ram_rd = !req_q.err && (req_q.wen == WEN_NONE);
                if (accept) begin
                    state_nxt = ST_FIRST;
                    cnt_nxt   = CNT_FIRST;
                end else begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = WAIT_W'(0);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = WAIT_W'(0);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= WAIT_W'(0);
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            ready_q      <= (state_nxt == ST_IDLE) || (state_nxt == ST_RESP);
            resp_valid_q <= (state_q == ST_RESP);
            resp_err_q   <= (state_q == ST_RESP) && req_q.err;
        end
    end

    // Request payload; only meaningful between accept and the response cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            req_q.wen   <= bus.req_wen;
            req_q.wdata <= bus.req_wdata;
            req_q.err   <= !in_range;
            idx_q       <= idx_in;
        end
    end

    dsram_bytelane_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (idx_q),
        .we    (ram_we),
        .wdata (req_q.wdata),
        .rd_en (ram_rd),
        .rdata (ram_q)
    );

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = ram_q;

endmodule

// File: tb/tb_dsram_responder.sv
// Bench for dsram_responder: two instances (different wait/base/depth) checked
// every cycle against a timing/storage model, plus directed literal checks.
module tb_dsram_responder;
    import dsram_pkg::*;

    localparam int unsigned W_A     = 1;
    localparam int unsigned W_B     = 3;
    localparam int unsigned DEPTH_A = 4096;
    localparam int unsigned DEPTH_B = 256;
    localparam logic [31:0] BASE_A  = 32'h0000_0000;
    localparam logic [31:0] BASE_B  = 32'h1000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  drv_valid = 2'b00;
    logic [3:0]  drv_wen   = 4'h0;
    logic [31:0] drv_addr  = 32'h0;
    logic [31:0] drv_wdata = 32'h0;

    dsram_responder_if bus_a ();
    dsram_responder_if bus_b ();

    assign bus_a.req_valid = drv_valid[0];
    assign bus_a.req_wen   = drv_wen;
    assign bus_a.req_addr  = drv_addr;
    assign bus_a.req_wdata = drv_wdata;
    assign bus_b.req_valid = drv_valid[1];
    assign bus_b.req_wen   = drv_wen;
    assign bus_b.req_addr  = drv_addr;
    assign bus_b.req_wdata = drv_wdata;

    dsram_responder #(.DEPTH_WORDS(DEPTH_A), .ADDR_BASE(BASE_A), .WAIT_CYCLES(W_A))
        u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    dsram_responder #(.DEPTH_WORDS(DEPTH_B), .ADDR_BASE(BASE_B), .WAIT_CYCLES(W_B))
        u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int n_vec = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic dut_ready(input bit d);
        return d ? bus_b.req_ready : bus_a.req_ready;
    endfunction
    function automatic logic dut_valid(input bit d);
        return d ? bus_b.resp_valid : bus_a.resp_valid;
    endfunction
    function automatic logic dut_err(input bit d);
        return d ? bus_b.resp_err : bus_a.resp_err;
    endfunction
    function automatic logic [31:0] dut_rdata(input bit d);
        return d ? bus_b.resp_rdata : bus_a.resp_rdata;
    endfunction

    function automatic longint wait_of(input bit d);
        return d ? longint'(W_B) : longint'(W_A);
    endfunction
    function automatic logic [31:0] base_of(input bit d);
        return d ? BASE_B : BASE_A;
    endfunction
    function automatic logic [31:0] bytes_of(input bit d);
        return d ? 32'(DEPTH_B * 4) : 32'(DEPTH_A * 4);
    endfunction

    // Model: each request answers at accept edge + wait + 1, storage is a sparse word map
    longint      edge_n = 0;
    bit          live   = 1'b0;
    bit          pend_v   [2];
    longint      pend_due [2];
    logic [3:0]  pend_wen [2];
    logic [31:0] pend_idx [2];
    logic [31:0] pend_wd  [2];
    bit          pend_err [2];
    bit          e_ready  [2];
    bit          e_valid  [2];
    bit          e_err    [2];
    logic [31:0] e_rdata  [2];
    logic [31:0] mem_m [longint];

    task automatic model_step(input bit d);
        logic [31:0] off;
        logic [31:0] w;
        longint      key;
        if (!rst_n) begin
            pend_v[d]  = 1'b0;
            e_ready[d] = 1'b0;
            e_valid[d] = 1'b0;
            e_err[d]   = 1'b0;
            e_rdata[d] = 32'h0;
            return;
        end
        e_valid[d] = 1'b0;
        e_err[d]   = 1'b0;
        e_rdata[d] = 32'h0;
        if (pend_v[d] && pend_due[d] == edge_n) begin
            key        = (longint'(d) << 32) + longint'(pend_idx[d]);
            e_valid[d] = 1'b1;
            e_err[d]   = pend_err[d];
            if (!pend_err[d]) begin
                w = mem_m.exists(key) ? mem_m[key] : 32'h0;
                if (pend_wen[d] == WEN_NONE) begin
                    e_rdata[d] = w;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (pend_wen[d][i]) w[8*i +: 8] = pend_wd[d][8*i +: 8];
                    end
                    mem_m[key] = w;
                end
            end
            pend_v[d] = 1'b0;
        end
        if (e_ready[d] && drv_valid[d]) begin
            off         = drv_addr - base_of(d);
            pend_err[d] = off >= bytes_of(d);
            pend_idx[d] = off / 32'd4;
            pend_wen[d] = drv_wen;
            pend_wd[d]  = drv_wdata;
            pend_due[d] = edge_n + wait_of(d) + 64'd1;
            pend_v[d]   = 1'b1;
        end
        e_ready[d] = !pend_v[d] || (pend_due[d] <= edge_n + 64'd1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            if (!rst_n) live = 1'b1;
            model_step(1'b0);
            model_step(1'b1);
        end
    end

    // Per-cycle compare of both instances against the model
    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                for (int i = 0; i < 2; i++) begin
                    check($sformatf("ready%0d@%0d", i, edge_n), 32'(dut_ready(1'(i))), 32'(e_ready[i]));
                    check($sformatf("valid%0d@%0d", i, edge_n), 32'(dut_valid(1'(i))), 32'(e_valid[i]));
                    check($sformatf("err%0d@%0d", i, edge_n),   32'(dut_err(1'(i))),   32'(e_err[i]));
                    check($sformatf("rdata%0d@%0d", i, edge_n), dut_rdata(1'(i)),      e_rdata[i]);
                end
            end
        end
    end

    // Present a request and hold it until the cycle the model says it is accepted
    task automatic issue(input bit d, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        bit acc;
        drv_wen      = wen;
        drv_addr     = addr;
        drv_wdata    = wdata;
        drv_valid    = 2'b00;
        drv_valid[d] = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = e_ready[d];
            @(negedge clk);
        end
        drv_valid = 2'b00;
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_resp(input bit d, input int bound, output bit got,
                             output logic [31:0] rd, output logic er, output int lat);
        got = 1'b0;
        rd  = 32'h0;
        er  = 1'b0;
        lat = 0;
        for (int i = 1; i <= bound && !got; i++) begin
            @(negedge clk);
            if (dut_valid(d) === 1'b1) begin
                got = 1'b1;
                rd  = dut_rdata(d);
                er  = dut_err(d);
                lat = i;
            end
        end
    endtask

    task automatic req_chk(input string name, input bit d, input logic [3:0] wen,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
        bit          got;
        logic [31:0] rd;
        logic        er;
        int          lat;
        issue(d, wen, addr, wdata);
        wait_resp(d, 20, got, rd, er, lat);
        check({name, "_got"},   32'(got), 32'd1);
        check({name, "_lat"},   32'(lat), 32'(exp_lat));
        check({name, "_rdata"}, rd,       exp_rd);
        check({name, "_err"},   32'(er),  32'(exp_err));
    endtask

    initial begin
        bit          got;
        logic [31:0] rd;
        logic        er;
        int          lat;

        // Reset held for three cycles, then released
        repeat (3) begin
            @(negedge clk);
            check("rst_ready_a", 32'(bus_a.req_ready), 32'd0);
            check("rst_valid_a", 32'(bus_a.resp_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready_a", 32'(bus_a.req_ready), 32'd1);
        check("post_rst_ready_b", 32'(bus_b.req_ready), 32'd1);

        // Full-word write then read, two-cycle latency
        req_chk("wr10", 1'b0, WEN_WORD, 32'h10, 32'hDEAD_BEEF, 2, 32'h0, 1'b0);
        req_chk("rd10", 1'b0, WEN_NONE, 32'h10, 32'h0,         2, 32'hDEAD_BEEF, 1'b0);
        req_chk("wr00", 1'b0, WEN_WORD, 32'h00, 32'h0BAD_F00D, 2, 32'h0, 1'b0);

        // Single byte lane update
        req_chk("wr20",  1'b0, WEN_WORD, 32'h20, 32'h1122_3344, 2, 32'h0, 1'b0);
        req_chk("wr20b", 1'b0, 4'b0100,  32'h20, 32'h00AA_0000, 2, 32'h0, 1'b0);
        req_chk("rd20",  1'b0, WEN_NONE, 32'h20, 32'h0,         2, 32'h11AA_3344, 1'b0);

        // Read accepted in the write's response cycle sees the new word
        issue(1'b0, WEN_WORD, 32'h30, 32'hCAFE_F00D);
        check("ready_in_wait", 32'(bus_a.req_ready), 32'd0);
        req_chk("rd30_b2b", 1'b0, WEN_NONE, 32'h30, 32'h0, 2, 32'hCAFE_F00D, 1'b0);

        // Out-of-range read and write; word 0 must survive
        req_chk("rd_oor", 1'b0, WEN_NONE, 32'h4000, 32'h0,         2, 32'h0, 1'b1);
        req_chk("wr_oor", 1'b0, WEN_WORD, 32'h4000, 32'hFFFF_FFFF, 2, 32'h0, 1'b1);
        req_chk("rd00",   1'b0, WEN_NONE, 32'h0000, 32'h0,         2, 32'h0BAD_F00D, 1'b0);

        // Offset base: below-base wrap, top word, one past the end, partial lanes
        req_chk("b_rd_below", 1'b1, WEN_NONE, BASE_B - 32'd4,     32'h0, 4, 32'h0, 1'b1);
        req_chk("b_rd_end",   1'b1, WEN_NONE, BASE_B + 32'h400,   32'h0, 4, 32'h0, 1'b1);
        req_chk("b_wr_top",   1'b1, WEN_WORD, BASE_B + 32'h3FE,   32'hA5A5_5A5A, 4, 32'h0, 1'b0);
        req_chk("b_wr_top_p", 1'b1, 4'b0011,  BASE_B + 32'h3FC,   32'hFFFF_1234, 4, 32'h0, 1'b0);
        req_chk("b_rd_top",   1'b1, WEN_NONE, BASE_B + 32'h3FC,   32'h0, 4, 32'hA5A5_1234, 1'b0);

        // Reset during WAIT drops the pending write and its response
        req_chk("b_wr40", 1'b1, WEN_WORD, BASE_B + 32'h40, 32'h1111_2222, 4, 32'h0, 1'b0);
        issue(1'b1, WEN_WORD, BASE_B + 32'h40, 32'h0000_0005);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_resp(1'b1, 8, got, rd, er, lat);
        check("no_resp_after_rst", 32'(got), 32'd0);
        req_chk("b_rd40", 1'b1, WEN_NONE, BASE_B + 32'h40, 32'h0, 4, 32'h1111_2222, 1'b0);
        req_chk("a_rd10_after_rst", 1'b0, WEN_NONE, 32'h10, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
